// File: rtl/ring_count_decoder_pkg.sv
// Shared constants, state type and word helpers for the ring counter receiver.
// Helpers work on zero-extended words up to RING_MAXW bits wide.
package ring_pkg;

    localparam int RING_WIDTH = 8;
    localparam int RING_IDXW  = 3;
    localparam int RING_LAPW  = 8;
    localparam int RING_MAXW  = 64;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } ring_state_e;

    function automatic logic is_onehot(input logic [RING_MAXW-1:0] word);
        return (word != {RING_MAXW{1'b0}}) &&
               ((word & (word - RING_MAXW'(1))) == {RING_MAXW{1'b0}});
    endfunction

    // Rotate left by one within the low 'width' bits; the top bit wraps to bit 0.
    function automatic logic [RING_MAXW-1:0] rotl1(input logic [RING_MAXW-1:0] word,
                                                   input int width);
        logic [RING_MAXW-1:0] mask;
        mask = {RING_MAXW{1'b1}} >> (RING_MAXW - width);
        return ((word << 1) | (word >> (width - 1))) & mask;
    endfunction

endpackage

// File: rtl/ring_count_decoder_enc.sv
// Combinational one-hot to binary encoder with a legality flag.
// The index ORs all set positions, so it is only meaningful when legal_o is high.
module onehot_index_enc
    import ring_pkg::*;
#(
    parameter int WIDTH = RING_WIDTH,
    parameter int IDXW  = RING_IDXW
) (
    input  logic [WIDTH-1:0] word_i,
    output logic [IDXW-1:0]  idx_o,
    output logic             legal_o
);

    logic [IDXW-1:0] acc_s;

    // OR together the positions of every set bit
    always_comb begin
        acc_s = {IDXW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            if (word_i[i]) begin
                acc_s = acc_s | IDXW'(i);
            end else begin
                acc_s = acc_s;
            end
        end
    end

    assign idx_o   = acc_s;
    assign legal_o = is_onehot(RING_MAXW'(word_i));

endmodule

// File: rtl/ring_count_decoder.sv
// Receiver/checker for a rotating one-hot ring word: tracks the sequence,
// decodes the position, counts completed laps and flags sequence errors.
module ring_count_decoder
    import ring_pkg::*;
#(
    parameter int WIDTH = RING_WIDTH,
    parameter int IDXW  = RING_IDXW,
    parameter int LAPW  = RING_LAPW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ring_in,
    input  logic             ring_valid,
    input  logic             ring_clr,
    input  logic             err_clr,
    output logic [IDXW-1:0]  idx,
    output logic             idx_valid,
    output logic             locked,
    output logic             err,
    output logic             err_sticky,
    output logic [LAPW-1:0]  lap_count,
    output logic             lap_pulse
);

    ring_state_e      state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic             sticky_q, sticky_d;
    logic [LAPW-1:0]  lap_q, lap_d;
    logic             pulse_q, pulse_d;

    logic [IDXW-1:0]  enc_idx_s;
    logic             enc_legal_s;
    logic [WIDTH-1:0] expected_s;
    logic             match_s;

    onehot_index_enc #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_enc (
        .word_i  (ring_in),
        .idx_o   (enc_idx_s),
        .legal_o (enc_legal_s)
    );

    // prev_q is always one-hot while LOCKED, so a match implies a legal word
    assign expected_s = WIDTH'(rotl1(RING_MAXW'(prev_q), WIDTH));
    assign match_s    = (ring_in == expected_s);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (ring_clr) begin
            state_d = UNLOCKED;
        end else if (ring_valid) begin
            case (state_q)
                UNLOCKED: state_d = enc_legal_s ? LOCKED : UNLOCKED;
                LOCKED:   state_d = match_s ? LOCKED : UNLOCKED;
                default:  state_d = UNLOCKED;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Next values for the registered outputs and tracking word
    always_comb begin
        prev_d   = prev_q;
        idx_d    = idx_q;
        locked_d = locked_q;
        err_d    = 1'b0;
        sticky_d = err_clr ? 1'b0 : sticky_q;
        lap_d    = lap_q;
        pulse_d  = 1'b0;
        if (ring_clr) begin
            locked_d = 1'b0;
            lap_d    = {LAPW{1'b0}};
        end else if (ring_valid) begin
            case (state_q)
                UNLOCKED: begin
                    if (enc_legal_s) begin
                        prev_d   = ring_in;
                        idx_d    = enc_idx_s;
                        locked_d = 1'b1;
                    end else begin
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                    end
                end
                LOCKED: begin
                    if (match_s) begin
                        prev_d = ring_in;
                        idx_d  = enc_idx_s;
                        if (prev_q[WIDTH-1]) begin
                            lap_d   = lap_q + LAPW'(1);
                            pulse_d = 1'b1;
                        end else begin
                            lap_d = lap_q;
                        end
                    end else begin
                        err_d    = 1'b1;
                        sticky_d = 1'b1;
                        locked_d = 1'b0;
                    end
                end
                default: begin
                    locked_d = 1'b0;
                end
            endcase
        end else begin
            locked_d = locked_q;
        end
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q   <= {WIDTH{1'b0}};
            idx_q    <= {IDXW{1'b0}};
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            sticky_q <= 1'b0;
            lap_q    <= {LAPW{1'b0}};
            pulse_q  <= 1'b0;
        end else begin
            prev_q   <= prev_d;
            idx_q    <= idx_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            sticky_q <= sticky_d;
            lap_q    <= lap_d;
            pulse_q  <= pulse_d;
        end
    end

    assign idx        = idx_q;
    assign idx_valid  = locked_q;
    assign locked     = locked_q;
    assign err        = err_q;
    assign err_sticky = sticky_q;
    assign lap_count  = lap_q;
    assign lap_pulse  = pulse_q;

endmodule

// File: tb/tb_ring_count_decoder.sv
// Bench for ring_count_decoder: directed vector table, hand-written corner
// sequences, and randomized traffic checked against a position-based model.
module tb_ring_count_decoder;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic [W-1:0] ring_in;
    logic         ring_valid;
    logic         ring_clr;
    logic         err_clr;
    logic [2:0]   idx;
    logic         idx_valid;
    logic         locked;
    logic         err;
    logic         err_sticky;
    logic [7:0]   lap_count;
    logic         lap_pulse;

    ring_count_decoder #(.WIDTH(8), .IDXW(3), .LAPW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .ring_in    (ring_in),
        .ring_valid (ring_valid),
        .ring_clr   (ring_clr),
        .err_clr    (err_clr),
        .idx        (idx),
        .idx_valid  (idx_valid),
        .locked     (locked),
        .err        (err),
        .err_sticky (err_sticky),
        .lap_count  (lap_count),
        .lap_pulse  (lap_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total  = 0;
    int n_passed = 0;

    // Behavioural model: position of the set bit and lap count as integers
    bit m_locked;
    int m_pos;
    int m_lap;
    bit m_err;
    bit m_sticky;
    bit m_pulse;

    typedef struct {
        bit         rst, val, clr, eclr;
        logic [7:0] word;
        int         e_idx;
        bit         e_lck, e_err, e_stk;
        int         e_lap;
        bit         e_pls;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(bit rst, bit val, bit clr, bit eclr, logic [7:0] word,
                                int e_idx, bit e_lck, bit e_err, bit e_stk, int e_lap, bit e_pls);
        vec_t v;
        v.rst = rst; v.val = val; v.clr = clr; v.eclr = eclr; v.word = word;
        v.e_idx = e_idx; v.e_lck = e_lck; v.e_err = e_err; v.e_stk = e_stk;
        v.e_lap = e_lap; v.e_pls = e_pls;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end else begin
            n_passed++;
        end
    endtask

    function automatic int pos_of(input logic [7:0] w);
        int p;
        p = 0;
        for (int i = 0; i < W; i++) if (w[i]) p = i;
        return p;
    endfunction

    task automatic model_step(input bit rst, input bit val, input bit clr, input bit eclr,
                              input logic [7:0] word);
        bit bad;
        bad     = 1'b0;
        m_err   = 1'b0;
        m_pulse = 1'b0;
        if (rst) begin
            m_locked = 1'b0; m_pos = 0; m_lap = 0; m_sticky = 1'b0;
        end else if (clr) begin
            m_locked = 1'b0;
            m_lap    = 0;
            if (eclr) m_sticky = 1'b0;
        end else if (val) begin
            if (!m_locked) begin
                if ($countones(word) == 1) begin
                    m_locked = 1'b1;
                    m_pos    = pos_of(word);
                end else begin
                    bad = 1'b1;
                end
            end else if (word == (8'(1) << ((m_pos + 1) % W))) begin
                if (m_pos == W - 1) begin
                    m_lap   = (m_lap + 1) % 256;
                    m_pulse = 1'b1;
                end
                m_pos = (m_pos + 1) % W;
            end else begin
                bad      = 1'b1;
                m_locked = 1'b0;
            end
            if (bad) begin
                m_err    = 1'b1;
                m_sticky = 1'b1;
            end else if (eclr) begin
                m_sticky = 1'b0;
            end
        end else if (eclr) begin
            m_sticky = 1'b0;
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then sample after the rising edge
    task automatic cyc(input bit rst, input bit val, input bit clr, input bit eclr,
                       input logic [7:0] word);
        @(negedge clk);
        reset      = rst;
        ring_valid = val;
        ring_clr   = clr;
        err_clr    = eclr;
        ring_in    = word;
        @(posedge clk);
        #1;
        model_step(rst, val, clr, eclr, word);
    endtask

    task automatic step_word(input logic [7:0] word);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, word);
    endtask

    initial begin
        logic [7:0] w;
        int         r;
        reset = 1'b1; ring_in = 8'h00; ring_valid = 1'b0; ring_clr = 1'b0; err_clr = 1'b0;

        // rst, val, clr, eclr, word | idx, locked, err, sticky, lap, lap_pulse
        tbl[0]  = mk(1, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 0, 8'h01, 0, 1, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 8'h02, 1, 1, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 0, 8'h04, 2, 1, 0, 0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 0, 8'h08, 3, 1, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 0, 0, 8'h10, 4, 1, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 0, 0, 8'h20, 5, 1, 0, 0, 0, 0);
        tbl[7]  = mk(0, 1, 0, 0, 8'h40, 6, 1, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 0, 0, 8'h80, 7, 1, 0, 0, 0, 0);
        tbl[9]  = mk(0, 1, 0, 0, 8'h01, 0, 1, 0, 0, 1, 1);
        tbl[10] = mk(0, 1, 0, 0, 8'h02, 1, 1, 0, 0, 1, 0);
        tbl[11] = mk(0, 1, 0, 0, 8'h08, 0, 0, 1, 1, 1, 0);
        tbl[12] = mk(0, 1, 0, 0, 8'h10, 4, 1, 0, 1, 1, 0);
        tbl[13] = mk(0, 1, 0, 0, 8'h10, 0, 0, 1, 1, 1, 0);
        tbl[14] = mk(0, 1, 0, 0, 8'h00, 0, 0, 1, 1, 1, 0);
        tbl[15] = mk(0, 1, 0, 0, 8'h03, 0, 0, 1, 1, 1, 0);
        tbl[16] = mk(0, 1, 0, 0, 8'h05, 0, 0, 1, 1, 1, 0);
        tbl[17] = mk(0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 18; i++) begin
            cyc(tbl[i].rst, tbl[i].val, tbl[i].clr, tbl[i].eclr, tbl[i].word);
            chk($sformatf("tbl%0d locked", i), locked, tbl[i].e_lck);
            chk($sformatf("tbl%0d idx_valid", i), idx_valid, tbl[i].e_lck);
            chk($sformatf("tbl%0d err", i), err, tbl[i].e_err);
            chk($sformatf("tbl%0d err_sticky", i), err_sticky, tbl[i].e_stk);
            chk($sformatf("tbl%0d lap_count", i), lap_count, tbl[i].e_lap);
            chk($sformatf("tbl%0d lap_pulse", i), lap_pulse, tbl[i].e_pls);
            if (tbl[i].e_lck || tbl[i].rst) chk($sformatf("tbl%0d idx", i), idx, tbl[i].e_idx);
        end

        // ring_clr resync after a completed lap
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int k = 0; k <= 8; k++) step_word(8'h01 << (k % 8));
        for (int k = 1; k <= 5; k++) step_word(8'h01 << k);
        chk("clr pre idx", idx, 5);
        chk("clr pre lap", lap_count, 1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 8'hFF);
        chk("clr locked", locked, 0);
        chk("clr idx_valid", idx_valid, 0);
        chk("clr err", err, 0);
        chk("clr lap", lap_count, 0);
        step_word(8'h01);
        chk("clr relock locked", locked, 1);
        chk("clr relock idx", idx, 0);
        chk("clr relock err", err, 0);
        chk("clr relock sticky", err_sticky, 0);

        // ring_valid gap holds state
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h55);
            chk("gap idx", idx, 0);
            chk("gap locked", locked, 1);
            chk("gap err", err, 0);
        end
        step_word(8'h02);
        chk("gap resume idx", idx, 1);
        chk("gap resume err", err, 0);

        // err_clr on the same edge as a mismatch: set wins
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h02);
        chk("eclr+err err", err, 1);
        chk("eclr+err sticky", err_sticky, 1);
        chk("eclr+err locked", locked, 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("eclr sticky", err_sticky, 0);
        chk("eclr err", err, 0);

        // Mid-run reset with five laps counted
        step_word(8'h01);
        for (int k = 1; k <= 40; k++) step_word(8'h01 << (k % 8));
        chk("rst pre lap", lap_count, 5);
        chk("rst pre locked", locked, 1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h02);
        chk("rst idx", idx, 0);
        chk("rst locked", locked, 0);
        chk("rst idx_valid", idx_valid, 0);
        chk("rst err", err, 0);
        chk("rst sticky", err_sticky, 0);
        chk("rst lap", lap_count, 0);
        chk("rst lap_pulse", lap_pulse, 0);

        // Randomized traffic against the model
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 99);
            if (m_locked && r < 70)      w = 8'h01 << ((m_pos + 1) % W);
            else if (r < 85)             w = 8'h01 << $urandom_range(0, 7);
            else                         w = 8'($urandom_range(0, 255));
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 49) == 0), ($urandom_range(0, 19) == 0), w);
            chk("rnd locked", locked, m_locked);
            chk("rnd idx_valid", idx_valid, m_locked);
            chk("rnd err", err, m_err);
            chk("rnd err_sticky", err_sticky, m_sticky);
            chk("rnd lap_count", lap_count, m_lap);
            chk("rnd lap_pulse", lap_pulse, m_pulse);
            chk("rnd err_and_pulse", err & lap_pulse, 0);
            if (m_locked) chk("rnd idx", idx, m_pos);
        end

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/ring_count_decoder.md
Name: ring_count_decoder

Overview:
- Receiving end of the one-hot ring counter link: samples a WIDTH-bit rotating one-hot word from a ring counter.
- Checks that each sample is the one-bit left rotation of the previous one, and decodes it to a binary index.
- Counts completed laps and flags sequence/encoding errors.
- Sits beside the ring source as its checker/consumer; downstream logic uses the index, the lap count and the error flags.

Parameters:
- WIDTH, 8, ring word width (>= 2)
- IDXW, 3, index width = clog2(WIDTH)
- LAPW, 8, lap counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ring_in  in  WIDTH  one-hot ring word from the source
- ring_valid  in  1  ring_in is sampled on this edge
- ring_clr  in  1  source was reset; resynchronise without error
- err_clr  in  1  clears err_sticky
- idx  out  IDXW  binary position of the set bit in the last accepted word
- idx_valid  out  1  idx is meaningful (equals locked)
- locked  out  1  decoder is tracking the sequence
- err  out  1  one-cycle pulse on an illegal or out-of-sequence sample
- err_sticky  out  1  latched error flag
- lap_count  out  LAPW  completed laps, wraps modulo 2^LAPW
- lap_pulse  out  1  one-cycle pulse on each completed lap

Behaviour:
- Registers, reset and latency
  - All outputs are registered.
  - A sample taken at edge N is reflected on the outputs immediately after edge N (1-cycle latency).
  - Reset: idx=0, idx_valid=0, locked=0, err=0, err_sticky=0, lap_count=0, lap_pulse=0, prev=0, state=UNLOCKED.
- Legal word: exactly one bit set. A zero word or a multi-bit word is illegal.
- Priority order: reset > ring_clr > sample (ring_valid) > hold.
- ring_valid=0: no state change; err=0 and lap_pulse=0; all other outputs hold.
- State UNLOCKED
  - Legal sample: prev<=ring_in, idx<=bit position, locked<=1, idx_valid<=1, state<=LOCKED. No lap counted.
  - Illegal sample: err pulses, err_sticky<=1, remain UNLOCKED.
- State LOCKED, expected word = rotate-left-by-one of prev (prev[WIDTH-1] wraps into bit 0)
  - Sample equals expected: prev and idx update.
  - If prev[WIDTH-1]=1 (wrap transition, e.g. 0x80 -> 0x01), lap_count increments (wrapping modulo 2^LAPW) and lap_pulse pulses.
  - Any other sample, including a repeat of prev or an illegal word: err pulses, err_sticky<=1, locked<=0, idx_valid<=0, state<=UNLOCKED. idx holds its last value, which is don't-care while idx_valid=0.
  - After an error, the next legal sample relocks as in UNLOCKED, with no error.
- ring_clr=1
  - ring_in is ignored that cycle.
  - state<=UNLOCKED, locked=0, idx_valid=0, lap_count<=0.
  - err is not pulsed and err_sticky is unchanged.
- err_clr
  - Clears err_sticky on the next edge.
  - If a new error is detected on the same edge, err_sticky stays 1 (set wins).
- err and lap_pulse are never high in the same cycle.

Decomposition:
- Package ring_pkg holds:
  - default WIDTH/IDXW/LAPW constants
  - state enum {UNLOCKED, LOCKED}
  - function is_onehot(word)
  - function rotl1(word)
- Sub-module onehot_index_enc: combinational WIDTH -> IDXW priority-free encoder plus a legal flag; instantiated once.
- The FSM, lap counter and flags live in the top.

Test Plan:
- Ring sequence: reset, then ring_valid=1 with 01,02,04,08,10,20,40,80,01.
  - locked=1 and idx=0 after the first edge.
  - idx steps 0..7, then 0.
  - lap_pulse high exactly once, after the 80->01 edge; lap_count=1; err never high.
- Skipped position: sequence 01,02,08.
  - On 08: err is a one-cycle pulse, err_sticky=1, locked=0, idx_valid=0.
  - Next sample 10: relocks with idx=4 and no err.
- Illegal words while unlocked: feed 00, then 03, then 05.
  - err pulses on each of the three samples; locked stays 0.
- ring_clr resync and ring_valid gaps:
  - Run to 20, then ring_clr=1 for 1 cycle, then 01: no err, lap_count=0, locked=1, idx=0.
  - Feed 01, hold ring_valid=0 for 3 cycles, then 02: no err, idx holds 0 then becomes 1.
- Flag clearing and mid-run reset:
  - err_clr asserted on the same edge as a mismatch: err_sticky remains 1.
  - err_clr alone on the next edge: err_sticky=0.
  - reset asserted mid-run with lap_count=5: all outputs are 0 after the next edge.
